// File: rtl/controlador_compuerta_param_if.sv
// Lane-side bundle for the parking entrance gate controller: sensors and keypad
// in, gate motor and alarm lines out.
interface controlador_compuerta_param_if #(
   parameter int CODE_W = 8,
   parameter int CNT_W  = 5
);
   logic              sEntrada;
   logic              sSalida;
   logic              sSalidaLote;
   logic              sEnter;
   logic [CODE_W-1:0] sCode;
   logic              sLoad;
   logic [CODE_W-1:0] sNewCode;
   logic              sAbrir;
   logic              sCerrar;
   logic              sBloq;
   logic              sAlmInc;
   logic              sAlmBloq;
   logic              sLleno;
   logic [CNT_W-1:0]  ocupacion;

   modport slave (
      input  sEntrada, sSalida, sSalidaLote, sEnter, sCode, sLoad, sNewCode,
      output sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq, sLleno, ocupacion
   );

   modport master (
      output sEntrada, sSalida, sSalidaLote, sEnter, sCode, sLoad, sNewCode,
      input  sAbrir, sCerrar, sBloq, sAlmInc, sAlmBloq, sLleno, ocupacion
   );
endinterface

// File: rtl/controlador_compuerta_param.sv
// Parametrised entrance gate controller with loadable code, occupancy count and
// full-lot inhibit. Define CODE_TIMEOUT_EN to enable the code-entry timeout.
module controlador_compuerta_param #(
   parameter int                CODE_W       = 8,
   parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(8'h38),
   parameter int                MAX_INTENTOS = 3,
   parameter int                CAPACITY     = 16,
   parameter int                CNT_W        = 5,
   parameter int                TIMEOUT_CYC  = 1000
) (
   input  logic                          clock,
   input  logic                          reset,
   controlador_compuerta_param_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_CODE = 3'd1,
      RELEASE   = 3'd2,
      OPEN      = 3'd3,
      ALARM_INC = 3'd4,
      BLOCK     = 3'd5
   } state_t;

   state_t            r_state, w_next;
   logic [7:0]        r_intentos, w_intentos;
   logic [CODE_W-1:0] r_code;
   logic [CNT_W-1:0]  r_ocup;
   logic              w_ok, w_lleno, w_inc, w_dec, w_timeout, w_in_code;

   assign w_ok      = bus.sEnter && (bus.sCode == r_code);
   assign w_lleno   = (r_ocup == CNT_W'(CAPACITY));
   assign w_inc     = (r_state == OPEN) && bus.sSalida && !bus.sEntrada;
   assign w_dec     = bus.sSalidaLote;
   assign w_in_code = (r_state == WAIT_CODE) || (r_state == RELEASE);

`ifdef CODE_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0] r_timer;

   // Fires on the TIMEOUT_CYC-th cycle spent in the code-entry states.
   assign w_timeout = w_in_code && (r_timer == TMR_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_timer <= '0;
      else if (w_in_code && (w_next == WAIT_CODE || w_next == RELEASE))
         r_timer <= r_timer + TMR_W'(1);
      else
         r_timer <= '0;
   end
`else
   assign w_timeout = (TIMEOUT_CYC < 0);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_intentos <= '0;
      end else begin
         r_state    <= w_next;
         r_intentos <= w_intentos;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_intentos = r_intentos;
      case (r_state)
         IDLE: begin
            if (bus.sEntrada && bus.sSalida)       w_next = BLOCK;
            else if (bus.sEntrada && !w_lleno)     w_next = WAIT_CODE;
         end
         WAIT_CODE: begin
            if (w_ok) begin
               w_next = OPEN;
            end else if (w_timeout) begin
               w_next     = IDLE;
               w_intentos = '0;
            end else if (bus.sEnter) begin
               // Saturate at the limit so the alarm holds a stable count.
               if (r_intentos >= 8'(MAX_INTENTOS - 1)) begin
                  w_next     = ALARM_INC;
                  w_intentos = 8'(MAX_INTENTOS);
               end else begin
                  w_next     = RELEASE;
                  w_intentos = r_intentos + 8'd1;
               end
            end
         end
         RELEASE: begin
            if (w_timeout) begin
               w_next     = IDLE;
               w_intentos = '0;
            end else if (!bus.sEnter) begin
               w_next = WAIT_CODE;
            end
         end
         OPEN: begin
            w_intentos = '0;
            if (bus.sSalida) w_next = bus.sEntrada ? BLOCK : IDLE;
         end
         ALARM_INC, BLOCK: begin
            if (w_ok) w_next = OPEN;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_code <= DEFAULT_CODE;
      else if (r_state == IDLE && bus.sLoad)
         r_code <= bus.sNewCode;
   end

   // Simultaneous entry and exit cancel; both ends saturate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_ocup <= '0;
      else if (w_inc && !w_dec && !w_lleno)
         r_ocup <= r_ocup + CNT_W'(1);
      else if (w_dec && !w_inc && r_ocup != '0)
         r_ocup <= r_ocup - CNT_W'(1);
   end

   always_comb begin
      bus.sAbrir   = 1'b0;
      bus.sCerrar  = 1'b1;
      bus.sBloq    = 1'b0;
      bus.sAlmInc  = 1'b0;
      bus.sAlmBloq = 1'b0;
      case (r_state)
         OPEN: begin
            bus.sAbrir  = 1'b1;
            bus.sCerrar = 1'b0;
         end
         ALARM_INC: bus.sAlmInc = 1'b1;
         BLOCK: begin
            bus.sBloq    = 1'b1;
            bus.sAlmBloq = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.sLleno    = w_lleno;
   assign bus.ocupacion = r_ocup;

endmodule

// File: tb/tb_controlador_compuerta_param.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares
// the gate outputs one cycle after each stimulus edge.
module tb_controlador_compuerta_param;
   localparam int         CODE_W = 8;
   localparam logic [7:0] DEF    = 8'h38;
   localparam int         MAXI   = 3;
   localparam int         CAP    = 2;
   localparam int         CNT_W  = 2;
   localparam int         TO     = 10;

   logic clock = 1'b0;
   logic reset = 1'b0;

   controlador_compuerta_param_if #(.CODE_W(CODE_W), .CNT_W(CNT_W)) bus ();

   controlador_compuerta_param #(
      .CODE_W(CODE_W), .DEFAULT_CODE(DEF), .MAX_INTENTOS(MAXI),
      .CAPACITY(CAP), .CNT_W(CNT_W), .TIMEOUT_CYC(TO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic abrir, cerrar, bloq, alminc, almbloq, lleno;
      logic [CNT_W-1:0] ocup;
   } obs_t;

   obs_t  exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   string tag      = "reset";

   // Behavioural reference: lane phase, failed-press tally, cars parked.
   localparam int P_IDLE = 0, P_CODE = 1, P_REL = 2, P_GATE = 3, P_ALARM = 4, P_BLOCK = 5;
   int         m_phase, m_fails, m_cars, m_elapsed;
   logic [7:0] m_code;

   task automatic m_reset();
      m_phase = P_IDLE; m_fails = 0; m_cars = 0; m_elapsed = 0; m_code = DEF;
   endtask

   function automatic obs_t m_obs();
      obs_t o;
      o.abrir   = (m_phase == P_GATE);
      o.cerrar  = (m_phase != P_GATE);
      o.bloq    = (m_phase == P_BLOCK);
      o.almbloq = (m_phase == P_BLOCK);
      o.alminc  = (m_phase == P_ALARM);
      o.lleno   = (m_cars == CAP);
      o.ocup    = CNT_W'(m_cars);
      return o;
   endfunction

   task automatic m_step(input logic ent, sal, lote, en, input logic [7:0] code,
                         input logic ld, input logic [7:0] nc);
      bit right   = en && (code == m_code);
      bit leave   = (m_phase == P_GATE) && sal && !ent;
      bit waiting = (m_phase == P_CODE) || (m_phase == P_REL);
      bit expired = 1'b0;
      int nph     = m_phase;
`ifdef CODE_TIMEOUT_EN
      expired = waiting && (m_elapsed + 1 >= TO);
`endif
      case (m_phase)
         P_IDLE: begin
            if (ld) m_code = nc;
            if (ent && sal) nph = P_BLOCK;
            else if (ent && m_cars < CAP) nph = P_CODE;
         end
         P_CODE: begin
            if (right) nph = P_GATE;
            else if (expired) begin nph = P_IDLE; m_fails = 0; end
            else if (en) begin
               m_fails = m_fails + 1;
               nph = (m_fails >= MAXI) ? P_ALARM : P_REL;
            end
         end
         P_REL: begin
            if (expired) begin nph = P_IDLE; m_fails = 0; end
            else if (!en) nph = P_CODE;
         end
         P_GATE: begin
            m_fails = 0;
            if (sal) nph = ent ? P_BLOCK : P_IDLE;
         end
         default: if (right) nph = P_GATE;
      endcase
      m_elapsed = (waiting && (nph == P_CODE || nph == P_REL)) ? m_elapsed + 1 : 0;
      if (leave && !lote)      m_cars = (m_cars < CAP) ? m_cars + 1 : m_cars;
      else if (lote && !leave) m_cars = (m_cars > 0) ? m_cars - 1 : 0;
      m_phase = nph;
   endtask

   task automatic check(input string name, input obs_t e);
      obs_t a;
      a = {bus.sAbrir, bus.sCerrar, bus.sBloq, bus.sAlmInc, bus.sAlmBloq, bus.sLleno, bus.ocupacion};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got abrir=%b cerrar=%b bloq=%b alminc=%b almbloq=%b lleno=%b ocup=%0d, want abrir=%b cerrar=%b bloq=%b alminc=%b almbloq=%b lleno=%b ocup=%0d",
                  name, a.abrir, a.cerrar, a.bloq, a.alminc, a.almbloq, a.lleno, a.ocup,
                  e.abrir, e.cerrar, e.bloq, e.alminc, e.almbloq, e.lleno, e.ocup);
      end
   endtask

   task automatic drive(input logic ent, sal, lote, en, input logic [7:0] code,
                        input logic ld, input logic [7:0] nc);
      @(negedge clock);
      bus.sEntrada = ent; bus.sSalida = sal; bus.sSalidaLote = lote;
      bus.sEnter = en; bus.sCode = code; bus.sLoad = ld; bus.sNewCode = nc;
      m_step(ent, sal, lote, en, code, ld, nc);
      exp_q.push_back(m_obs());
      @(posedge clock);
   endtask

   task automatic idle(); drive(0, 0, 0, 0, 8'h00, 0, 8'h00); endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(posedge clock);
         #1;
         if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, e);
         end
      end
   end

   initial begin : stim
      obs_t rst_obs;
      rst_obs = '{abrir: 1'b0, cerrar: 1'b1, bloq: 1'b0, alminc: 1'b0,
                  almbloq: 1'b0, lleno: 1'b0, ocup: '0};
      bus.sEntrada = 0; bus.sSalida = 0; bus.sSalidaLote = 0; bus.sEnter = 0;
      bus.sCode = 0; bus.sLoad = 0; bus.sNewCode = 0;
      m_reset();
      #1 reset = 1'b1;
      #1 check("reset", rst_obs);
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b0;

      tag = "normal_entry";
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h38, 0, 8'h00);
      idle();
      drive(0, 1, 0, 0, 8'h00, 0, 8'h00);

      tag = "attempts_alarm";
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      repeat (3) begin
         drive(0, 0, 0, 1, 8'h00, 0, 8'h00);
         idle();
      end
      drive(0, 0, 0, 1, 8'h38, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00, 0, 8'h00);

      tag = "full_lot";
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      idle();
      drive(0, 0, 1, 0, 8'h00, 0, 8'h00);

      tag = "block";
      drive(1, 1, 0, 0, 8'h00, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h00, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h38, 0, 8'h00);
      tag = "exit_and_lot_leave";
      drive(0, 1, 1, 0, 8'h00, 0, 8'h00);

      tag = "code_load";
      drive(0, 0, 0, 0, 8'h00, 1, 8'hA5);
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h38, 0, 8'h00);
      idle();
      drive(0, 0, 0, 1, 8'hA5, 0, 8'h00);
      drive(0, 0, 0, 0, 8'h00, 1, 8'h5A);
      drive(0, 1, 0, 0, 8'h00, 0, 8'h00);
      drive(0, 0, 1, 0, 8'h00, 0, 8'h00);
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      drive(0, 0, 0, 1, 8'hA5, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00, 0, 8'h00);
      drive(0, 0, 1, 0, 8'h00, 0, 8'h00);

      tag = "timeout_window";
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      repeat (12) idle();
      drive(0, 0, 0, 1, 8'hA5, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00, 0, 8'h00);

      tag = "drain_lot";
      repeat (3) drive(0, 0, 1, 0, 8'h00, 0, 8'h00);
      tag = "reset_in_alarm";
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      repeat (3) begin
         drive(0, 0, 0, 1, 8'h00, 0, 8'h00);
         idle();
      end
      @(negedge clock);
      #2 reset = 1'b1;
      #1 check("async_reset_mid_op", rst_obs);
      m_reset();
      @(posedge clock);
      @(negedge clock) reset = 1'b0;
      tag = "default_code_after_reset";
      drive(1, 0, 0, 0, 8'h00, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h38, 0, 8'h00);
      drive(0, 1, 0, 0, 8'h00, 0, 8'h00);

      tag = "random";
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] rc;
         rc = ($urandom_range(0, 1) == 1) ? m_code : 8'($urandom);
         drive(logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 9) < 2),
               logic'($urandom_range(0, 9) < 1), logic'($urandom_range(0, 9) < 4),
               rc, logic'($urandom_range(0, 19) == 0), 8'($urandom));
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/controlador_compuerta_param.md
Name: controlador_compuerta_param

Overview:
- Parametrised successor of the single-lane parking entrance gate controller.
- Adds the following over the previous controller:
  - configurable code width and attempt limit;
  - a run-time loadable access code;
  - a lot occupancy counter with a full-lot inhibit;
  - an optional code-entry timeout.
- Sits between the lane sensors / keypad and the gate motor driver and alarm outputs.

Parameters:
CODE_W, 8, width of the access code in bits
DEFAULT_CODE, 8'h38, access code loaded at reset (CODE_W bits)
MAX_INTENTOS, 3, wrong-code entries that trigger the attempts alarm (1..255)
CAPACITY, 16, lot capacity in vehicles (>=1)
CNT_W, 5, occupancy counter width; must satisfy 2**CNT_W > CAPACITY
TIMEOUT_CYC, 1000, code-entry timeout in clock cycles (used only with CODE_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
sEntrada  in  1  vehicle present at entry sensor
sSalida  in  1  vehicle cleared gate (passed through)
sSalidaLote  in  1  one-cycle pulse: vehicle left the lot via exit lane
sEnter  in  1  keypad enter, level
sCode  in  CODE_W  keypad code
sLoad  in  1  one-cycle pulse: program new code
sNewCode  in  CODE_W  code to program
sAbrir  out  1  open gate
sCerrar  out  1  close gate
sBloq  out  1  system blocked
sAlmInc  out  1  wrong-attempts alarm
sAlmBloq  out  1  block alarm
sLleno  out  1  lot full
ocupacion  out  CNT_W  vehicles currently in lot

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, attempts=0, code register=DEFAULT_CODE, ocupacion=0, timer=0.
  - Outputs: sCerrar=1; all other 1-bit outputs 0.
- Outputs are Moore decodes of the registered state. They change in the cycle after the transition-causing input is sampled.
- States and outputs:
  - IDLE: sCerrar=1.
    - sEntrada&sSalida -> BLOCK.
    - sEntrada&!sSalida&!sLleno -> WAIT_CODE.
    - sEntrada while sLleno -> stay IDLE.
  - WAIT_CODE: sCerrar=1. When sEnter is sampled:
    - sCode==code -> OPEN.
    - Otherwise attempts+1. If the new value >= MAX_INTENTOS -> ALARM_INC, else -> RELEASE.
  - RELEASE: sCerrar=1.
    - !sEnter -> WAIT_CODE. Exactly one attempt is counted per sEnter press.
  - OPEN: sAbrir=1, sCerrar=0; attempts cleared to 0.
    - sSalida&sEntrada -> BLOCK.
    - sSalida&!sEntrada -> IDLE, and ocupacion increments.
  - ALARM_INC: sAlmInc=1, sCerrar=1.
    - sEnter with correct code -> OPEN.
    - Wrong codes: no change; attempts saturate at MAX_INTENTOS.
  - BLOCK: sBloq=1, sAlmBloq=1, sCerrar=1.
    - sEnter with correct code -> OPEN.
  - Illegal state encoding -> IDLE on the next clock.
- Occupancy:
  - Increment on the OPEN->IDLE exit; decrement on sSalidaLote.
  - Both in the same cycle -> unchanged.
  - Decrement at 0 is ignored; increment at CAPACITY is ignored (saturating).
- sLleno = (ocupacion == CAPACITY), combinational from the register.
- Code load:
  - sLoad is accepted only in IDLE; the code register takes sNewCode at that clock edge.
  - sLoad is ignored in all other states.
  - The new code is effective from the next cycle.
- Code comparison is full CODE_W bits, unsigned equality.

Optional Feature:
- CODE_TIMEOUT_EN defined:
  - A timer counts cycles spent in WAIT_CODE or RELEASE.
  - Reaching TIMEOUT_CYC with no correct code -> IDLE, with attempts cleared and the timer cleared.
  - The timer restarts on each entry to WAIT_CODE from IDLE. It does not restart on RELEASE->WAIT_CODE.
  - Correct code on the same cycle as the timeout: correct code wins (-> OPEN).
- Undefined: no timer logic; WAIT_CODE waits indefinitely.

Test Plan:
- Normal entry:
  - reset; sEntrada=1; sEnter with sCode=8'h38 -> OPEN, sAbrir=1.
  - sSalida=1 -> IDLE, sCerrar=1, ocupacion=1.
- Attempts alarm:
  - Three wrong codes (8'h00), each with sEnter released in between -> sAlmInc=1 after the third.
  - Correct code -> sAlmInc=0, sAbrir=1.
- Block:
  - sEntrada=1 and sSalida=1 together in IDLE -> sBloq=1, sAlmBloq=1.
  - Wrong code -> no change; 8'h38 -> OPEN.
- Full lot:
  - With CAPACITY=2, admit 2 vehicles -> sLleno=1.
  - sEntrada -> stays IDLE.
  - sSalidaLote pulse -> ocupacion=1, sLleno=0.
  - sSalidaLote and an OPEN exit in the same cycle -> ocupacion unchanged.
- Code load:
  - sLoad with sNewCode=8'hA5 in IDLE; 8'h38 is then rejected, 8'hA5 opens.
  - sLoad asserted in OPEN -> code unchanged.
- Reset mid-operation and timeout (CODE_TIMEOUT_EN, TIMEOUT_CYC=10):
  - Reset asserted in ALARM_INC -> outputs return to reset values immediately, without a clock edge.
  - Idle 10 cycles in WAIT_CODE -> IDLE, attempts=0.
